// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receiver and transmitter.
//   UART_DATA_BITS     : data bits per frame (LSB first)
//   UART_CLKS_PER_BIT  : default bit period in clk cycles (10 MHz / 115200)
//   uart_state_t       : receiver state encoding, 3 bits
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for a single asynchronous input bit.
//   clk   : destination clock
//   reset : asynchronous active-high reset, loads RESET_VAL into both flops
//   d     : asynchronous input
//   q     : synchronised output, two cycles after d
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages reset to the same value so the output is stable and
    // reads the line's idle level straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit.
// Good bytes are presented as a one-cycle write strobe to the receive FIFO.
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   rx        : asynchronous serial line, idles high
//   fifo_full : downstream FIFO full flag
//   err_clr   : one-cycle pulse clearing frame_err and overrun
//   rx_data   : last good byte, held between strobes
//   rx_valid  : one-cycle write strobe for rx_data
//   rx_busy   : high whenever the receiver is not idle
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, good byte dropped because the FIFO was full
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       fifo_full,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

    uart_state_t                state;
    logic [CNT_W-1:0]           cnt;
    logic [IDX_W-1:0]           bit_idx;
    logic [UART_DATA_BITS-1:0]  shreg;
    logic                       rx_s;
    logic                       rx_q;
    logic                       stop_sample;
    logic                       frame_set;
    logic                       overrun_set;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // One extra delay of the synchronised line, used only to spot the
    // high-to-low transition that marks a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q <= 1'b1;
        end else begin
            rx_q <= rx_s;
        end
    end

    // The stop-bit sample point decides between a good byte, an overrun
    // and a framing error; the flag logic below needs the same decision.
    always_comb begin
        stop_sample = (state == STOP) && (cnt == LAST);
        frame_set   = stop_sample && !rx_s;
        overrun_set = stop_sample && rx_s && fifo_full;
    end

    // Receiver state machine with its bit-period counter and shifter.
    // START waits half a bit to confirm the start level at mid-bit, after
    // which every sample is one full bit period after the previous one.
    // A byte is only written out if the stop bit is high and the FIFO has
    // room; otherwise rx_data keeps the last good byte. A low stop bit
    // parks the FSM in BREAK so a held-low line cannot look like a new
    // start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_q && !rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= BREAK;
                        end else begin
                            state <= IDLE;
                            if (!fifo_full) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky error flags. A new error in the same cycle as err_clr must
    // not be lost, so the set condition takes priority over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Busy covers every non-idle state, including BREAK.
    always_comb begin
        rx_busy = (state != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Self-checking bench for uart_rx with CLKS_PER_BIT = 8.
// Frames expected to be written to the FIFO are queued with the cycle on
// which rx_valid must appear; a negedge monitor pops and compares them.
module tb_uart_rx;

    localparam int CPB = 8;
    // Pin falls just after edge N; the stop sample lands on edge N+79 and
    // rx_valid is seen high in the cycle that follows it.
    localparam int STROBE_LAT = 3 + (CPB - 1) / 2 + 1 + 9 * CPB;

    typedef struct {
        logic [7:0] data;
        int         cycle;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       fifo_full;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int   cycle;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    exp_t exp_item;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .fifo_full (fifo_full),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)",
                     tag, actual, expected, cycle);
        end
    endtask

    // Hold rx at one level for a whole bit period; ends #1 after an edge.
    task automatic driveBit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Send one complete frame starting now (#1 after an edge). When the
    // byte should reach the FIFO, its data and strobe cycle are queued.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input bit expect_strobe);
        exp_t e;
        e.data  = data;
        e.cycle = cycle + STROBE_LAT;
        if (expect_strobe) exp_q.push_back(e);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        driveBit(stop_bit);
    endtask

    task automatic idleCycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued frame
    // in both data and timing.
    always @(negedge clk) begin
        if (rx_valid) begin
            checkOutput("strobe_pending", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_item = exp_q.pop_front();
                checkOutput("strobe_data", rx_data, exp_item.data);
                checkOutput("strobe_cycle", cycle, exp_item.cycle);
            end
        end
    end

    initial begin
        cycle     = 0;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        rx        = 1'b1;
        fifo_full = 1'b0;
        err_clr   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_rx_busy", rx_busy, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_overrun", overrun, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        idleCycles(5);

        // Plain good frame.
        $display("[TB] frame 0xA5");
        applyStimulus(8'hA5, 1'b1, 1'b1);
        idleCycles(10);
        checkOutput("a5_frame_err", frame_err, 0);
        checkOutput("a5_overrun", overrun, 0);
        checkOutput("a5_idle", rx_busy, 0);

        // Back-to-back frames with a single stop bit and no gap.
        $display("[TB] back-to-back 0x00, 0xFF");
        applyStimulus(8'h00, 1'b1, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        idleCycles(10);
        checkOutput("b2b_rx_data", rx_data, 8'hFF);
        checkOutput("b2b_frame_err", frame_err, 0);

        // Short low glitch: start is rejected at mid-bit.
        $display("[TB] 2-cycle glitch");
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("glitch_busy_in_start", rx_busy, 1);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("glitch_busy_after", rx_busy, 0);
        checkOutput("glitch_frame_err", frame_err, 0);
        checkOutput("glitch_overrun", overrun, 0);
        idleCycles(10);

        // Low stop bit followed by a held-low line.
        $display("[TB] framing error 0x3C");
        applyStimulus(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (30 - CPB) @(posedge clk);
        #1;
        checkOutput("ferr_set", frame_err, 1);
        checkOutput("ferr_busy_break", rx_busy, 1);
        checkOutput("ferr_rx_data_held", rx_data, 8'hFF);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ferr_break_exit", rx_busy, 0);
        checkOutput("ferr_still_sticky", frame_err, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checkOutput("ferr_cleared", frame_err, 0);
        idleCycles(10);

        // FIFO full at the stop sample, with err_clr landing on the same
        // edge as the overrun set.
        $display("[TB] overrun 0x55");
        fifo_full = 1'b1;
        fork
            applyStimulus(8'h55, 1'b1, 1'b0);
            begin
                repeat (STROBE_LAT - 1) @(posedge clk);
                #1;
                err_clr = 1'b1;
                @(posedge clk);
                #1;
                err_clr = 1'b0;
            end
        join
        fifo_full = 1'b0;
        idleCycles(2);
        checkOutput("ovr_set", overrun, 1);
        checkOutput("ovr_rx_data_held", rx_data, 8'hFF);
        checkOutput("ovr_no_frame_err", frame_err, 0);
        idleCycles(10);

        // Reset in the middle of data bit 4 of 0x81.
        $display("[TB] reset mid-frame 0x81");
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        driveBit(1'b0);
        driveBit(1'b0);
        rx = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        checkOutput("midrst_rx_data", rx_data, 8'h00);
        checkOutput("midrst_rx_valid", rx_valid, 0);
        checkOutput("midrst_rx_busy", rx_busy, 0);
        checkOutput("midrst_overrun", overrun, 0);
        checkOutput("midrst_frame_err", frame_err, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idleCycles(20);
        applyStimulus(8'h42, 1'b1, 1'b1);
        idleCycles(10);
        checkOutput("post_rst_rx_data", rx_data, 8'h42);

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver sitting directly upstream of the receive FIFO. Synchronises the asynchronous `rx` pin, detects and validates start bits, samples 8 data bits (LSB first) at mid-bit, checks one stop bit, and presents each good byte as a one-cycle write strobe plus data. Flags framing and overrun errors as sticky status bits for the register/IRQ logic.

## Interface
- `CLKS_PER_BIT`, 87: clock cycles per bit (10 MHz / 115200); legal range 4..65535.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `rx`  input  1  serial line, asynchronous to `clk`; idles high.
- `fifo_full`  input  1  full flag from the downstream FIFO.
- `err_clr`  input  1  one-cycle pulse; clears `frame_err` and `overrun`.
- `rx_data`  output  8  last received byte; drives the FIFO `data_in`.
- `rx_valid`  output  1  one-cycle strobe; drives the FIFO `wr_en`.
- `rx_busy`  output  1  high whenever the state is not IDLE.
- `frame_err`  output  1  sticky; stop bit sampled low.
- `overrun`  output  1  sticky; good byte dropped because `fifo_full` was high.

## Operation
- Reset values: `rx_data`=0x00, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0; state IDLE, counters 0; both synchroniser flops reset to 1, so the line reads idle after reset.
- `rx_s` is the 2-flop synchronised `rx`; `rx_q` is `rx_s` delayed by one cycle.
- Bit counter `cnt`: width clog2(CLKS_PER_BIT). `HALF` = (CLKS_PER_BIT-1)/2, integer division.
- State machine:
  - IDLE: on `rx_q`=1 and `rx_s`=0 (falling edge), go to START with `cnt`=0.
  - START: increment `cnt`. At `cnt`==HALF, sample `rx_s`:
    - 0: go to DATA, `cnt`=0, `bit_idx`=0.
    - 1: glitch; return to IDLE with no flags.
  - DATA: increment `cnt`. At `cnt`==CLKS_PER_BIT-1, shift `rx_s` into the shift register MSB (shift right), reset `cnt`, increment `bit_idx`. After the 8th sample go to STOP.
  - STOP: at `cnt`==CLKS_PER_BIT-1, sample `rx_s`:
    - 1 and `fifo_full`=0: load `rx_data`, pulse `rx_valid`, go to IDLE.
    - 1 and `fifo_full`=1: no strobe, `rx_data` unchanged, set `overrun`, go to IDLE.
    - 0: no strobe, `rx_data` unchanged, set `frame_err`, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This covers a line held low (break) and prevents a spurious restart.
- `err_clr` and a simultaneous set in the same cycle: the set wins.
- `rx_data` holds its value between strobes; the FIFO samples it on the `rx_valid` cycle.

## Timing
- Synchroniser latency: 2 cycles from `rx` to `rx_s`. The start edge is detected 3 cycles after the pin falls.
- Sample points: start-bit check HALF+1 cycles after edge detection. Each data bit and the stop bit are sampled CLKS_PER_BIT cycles after the previous sample.
- `rx_valid`, `rx_data`, `frame_err` and `overrun` are registered and change in the cycle after the stop-bit sample edge. `rx_valid` is high for exactly 1 cycle.
- Back-to-back frames: the IDLE→START transition can occur in the cycle immediately after leaving STOP, so a 1-bit stop with no idle gap is received.
- Asynchronous reset mid-frame: the partial byte is discarded with no strobe. After release the receiver waits for a fresh falling edge.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, BREAK, 3-bit encoding);
  - `UART_DATA_BITS`=8;
  - default `CLKS_PER_BIT` constant, shared with the UART transmitter.
- Sub-module `sync_2ff`: a 1-bit two-flop synchroniser with reset value as a parameter (1 here), reusable for other pin inputs.
- The remainder (FSM, counters, shifter, flags) stays in `uart_rx`.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Reset then frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop=1 -> one `rx_valid` pulse with `rx_data`=0xA5 exactly 1 cycle after the stop sample; no error flags.
- Two back-to-back frames 0x00 then 0xFF with no idle gap -> two strobes 80 cycles apart, data 0x00 then 0xFF.
- 2-cycle low glitch on idle `rx` -> returns to IDLE; no strobe, no flags; `rx_busy` high only during START.
- Frame 0x3C with stop bit low, line held low 30 cycles -> `frame_err`=1, no strobe, FSM in BREAK until the line rises; `err_clr` then clears `frame_err`.
- Frame 0x55 with `fifo_full`=1 at the stop sample -> no strobe, `overrun`=1, `rx_data` keeps its previous value.
- Assert `reset` in the middle of bit 4 of frame 0x81, release, send 0x42 -> only 0x42 is strobed; all outputs read 0 during reset.
